pe_mux_stream: RTL

- N-input, signed W-bit operand selector for the PE datapath, with a registered output stage and valid/ready handshakes on every input and on the output.
- Generalises the combinational 2:1 PE mux in three ways: N channels, two selection modes (fixed index or round-robin), and one-cycle pipelined, back-pressure-aware transfer.
- Sits between operand sources (buffers, forwarding paths) and the PE MAC input.

---
 rtl/pe_pkg.sv | 8 +
 rtl/pe_rr_arbiter.sv | 26 ++
 rtl/pe_mux_stream.sv | 92 +++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE operand datapath.
package pe_pkg;

   typedef enum logic {MODE_FIXED, MODE_RR} pe_mux_mode_e;

   localparam int PE_DATA_W = 24;

endpackage

// File: rtl/pe_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after
// ptr (wrapping modulo N) wins. The pointer register lives in the parent.
module pe_rr_arbiter #(
   parameter  int N    = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] grant,
   output logic            any_req
);

   int idx;

   // Walk offsets from farthest to nearest so the offset closest to ptr wins.
   always_comb begin
      grant   = '0;
      any_req = |req;
      idx     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) grant = SELW'(idx);
      end
   end

endmodule

// File: rtl/pe_mux_stream.sv
// N-channel signed operand selector feeding the PE MAC, with fixed-index or
// round-robin selection and a single back-pressure-aware output register.
module pe_mux_stream
   import pe_pkg::*;
#(
   parameter  int W    = PE_DATA_W,
   parameter  int N    = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode,
   input  logic [SELW-1:0]     sel,
   input  logic [N-1:0]        in_valid,
   output logic [N-1:0]        in_ready,
   input  logic [N*W-1:0]      in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_data,
   output logic [SELW-1:0]     out_src
);

   localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

   pe_mux_mode_e        mode_e;
   logic [SELW-1:0]     rr_ptr;
   logic [SELW-1:0]     rr_grant;
   logic                rr_any;
   logic [SELW-1:0]     g;
   logic [SELW-1:0]     g_next;
   logic                g_ok;
   logic                load_en;
   logic                xfer;
   logic signed [W-1:0] g_data;

   assign mode_e  = pe_mux_mode_e'(mode);
   assign load_en = !out_valid || out_ready;

   pe_rr_arbiter #(.N(N)) u_arb (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .grant   (rr_grant),
      .any_req (rr_any)
   );

   // Selected channel and whether it is a legal grant this cycle.
   always_comb begin
      g    = '0;
      g_ok = 1'b0;
      if (mode_e == MODE_RR) begin
         g    = rr_grant;
         g_ok = rr_any;
      end else begin
         g    = sel;
         g_ok = ({1'b0, sel} < N_EXT);
      end
   end

   always_comb begin
      in_ready = '0;
      xfer     = 1'b0;
      g_data   = '0;
      for (int i = 0; i < N; i++) begin
         if (g_ok && (g == SELW'(i))) begin
            in_ready[i] = load_en;
            xfer        = load_en && in_valid[i];
            g_data      = in_data[i*W +: W];
         end
      end
   end

   assign g_next = (g == SELW'(N - 1)) ? '0 : g + SELW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         rr_ptr    <= '0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            out_src   <= g;
            if (mode_e == MODE_RR) rr_ptr <= g_next;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
